// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and the queued request layout shared by the ALU command sequencer
package alu_pkg;
    typedef enum logic [3:0] {OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3} op_e;
    localparam logic [3:0] OP_MAX = 4'd3;
    localparam int TAG_MAX_W = 8;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
    typedef struct packed {
        logic [7:0]           a;
        logic [7:0]           b;
        logic [3:0]           op;
        logic [TAG_MAX_W-1:0] tag;
    } req_t;
    function automatic logic is_legal(req_t r);
        return r.op <= OP_MAX && !(r.op == OP_DIV && r.b == 8'd0);
    endfunction
endpackage

// File: rtl/alu_req_fifo.sv
// alu_req_fifo: synchronous FIFO with a count register separating full from empty
module alu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0] r_cnt;
    logic w_push, w_pop;
    assign w_pop  = pop && r_cnt != '0;
    assign w_push = push && (r_cnt != FULL_CNT || w_pop);
    assign dout   = r_mem[r_rd];
    assign full   = r_cnt == FULL_CNT;
    assign empty  = r_cnt == '0;
    assign count  = r_cnt;
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr] <= din;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
        end
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues tagged ALU requests, issues them one at a time and returns tagged results
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_a,
    input  logic [7:0]       req_b,
    input  logic [3:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_sel,
    input  logic [15:0]      alu_out,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_data,
    output logic             rsp_carry,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);
    localparam int CW = $clog2(ALU_LAT + 1);
    localparam int AW = $clog2(DEPTH);
    state_e r_state, w_next;
    req_t w_push_data, w_head;
    logic w_full, w_empty, w_pop, w_legal, w_load, w_screen, w_capture, w_done;
    logic [AW:0] w_count;
    logic [CW-1:0] r_lat;
    logic [TAG_W-1:0] r_tag;
    assign req_ready   = !w_full;
    assign w_push_data = '{a: req_a, b: req_b, op: req_op, tag: TAG_MAX_W'(req_tag)};
    assign w_legal     = is_legal(w_head);
    assign busy        = w_count != '0 || r_state != IDLE;
    alu_req_fifo #(.DEPTH(DEPTH), .W($bits(req_t))) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid && req_ready),
        .din   (w_push_data),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );
    always_ff @(posedge clk)
        r_state <= rst ? IDLE : w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_pop ? (w_legal ? ISSUE : RESP) : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = r_lat == CW'(1) ? RESP : WAIT;
            RESP:    w_next = rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        w_pop     = r_state == IDLE && !w_empty && !rsp_valid;
        w_load    = w_pop && w_legal;
        w_screen  = w_pop && !w_legal;
        w_capture = r_state == WAIT && r_lat == CW'(1);
        w_done    = r_state == RESP && rsp_valid && rsp_ready;
    end
    // The head entry is gone once popped, so its tag is kept for the later capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            r_lat     <= '0;
            r_tag     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_tag   <= '0;
        end else begin
            if (w_load) begin
                alu_a   <= w_head.a;
                alu_b   <= w_head.b;
                alu_sel <= w_head.op;
            end
            if (w_pop) r_tag <= TAG_W'(w_head.tag);
            r_lat <= r_state == ISSUE ? CW'(ALU_LAT) : r_state == WAIT ? r_lat - CW'(1) : r_lat;
            if (w_screen || w_capture) begin
                rsp_valid <= 1'b1;
                rsp_data  <= w_capture ? alu_out : '0;
                rsp_carry <= w_capture && alu_carry;
                rsp_err   <= w_screen;
                rsp_tag   <= w_screen ? TAG_W'(w_head.tag) : r_tag;
            end else if (w_done) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed checks of the ALU command sequencer against a registered ALU model
module tb_alu_cmd_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0, req_ready;
    logic [7:0] req_a = '0, req_b = '0;
    logic [3:0] req_op = '0, req_tag = '0;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_sel;
    logic [15:0] alu_out = '0;
    logic alu_carry = 1'b0;
    logic rsp_valid, rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic rsp_carry, rsp_err;
    logic [3:0] rsp_tag;
    logic busy;
    logic [20:0] rsp_log[$];
    logic [22:0] snap;
    int checks = 0, errors = 0, stalls = 0;

    alu_cmd_sequencer #(.DEPTH(4), .TAG_W(4), .ALU_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err), .rsp_tag(rsp_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Registered ALU: one cycle from input sample to output
    always @(posedge clk) begin
        alu_out <= alu_sel == 4'd0 ? 16'(alu_a) + 16'(alu_b) :
                   alu_sel == 4'd1 ? 16'(alu_a) - 16'(alu_b) :
                   alu_sel == 4'd2 ? 16'(alu_a) * 16'(alu_b) :
                   alu_b != 8'd0 ? 16'(alu_a / alu_b) : 16'hFFFF;
        alu_carry <= (alu_sel == 4'd0 && 9'(alu_a) + 9'(alu_b) > 9'd255) || (alu_sel == 4'd1 && alu_a < alu_b);
    end

    always @(negedge clk)
        if (!rst && rsp_valid && rsp_ready) rsp_log.push_back({rsp_err, rsp_tag, rsp_data});

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input logic [3:0] tg);
        int n = 0;
        req_a = a;
        req_b = b;
        req_op = op;
        req_tag = tg;
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            step();
            n++;
            stalls++;
        end
        if (!req_ready) check("send_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        int c = 0;
        while (rsp_log.size() < n && c < 200) begin
            step();
            c++;
        end
        check("rsp_count", 32'(rsp_log.size()), 32'(n));
    endtask

    task automatic check_rsp(input string name, input int idx, input logic err, input logic [3:0] tg, input logic [15:0] data);
        logic [20:0] got;
        got = idx < rsp_log.size() ? rsp_log[idx] : 'x;
        check(name, 32'(got), 32'({err, tg, data}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        check("rst_rsp", 32'({rsp_carry, rsp_err, rsp_tag, rsp_data}), 32'd0);
        rst = 1'b0;
        // single add with exact latency
        send(8'd200, 8'd100, 4'd0, 4'd3);
        step();
        check("t1_alu_load", 32'({alu_a, alu_b, alu_sel}), 32'({8'd200, 8'd100, 4'd0}));
        check("t1_valid_e1", 32'(rsp_valid), 32'd0);
        step();
        check("t1_valid_e2", 32'(rsp_valid), 32'd0);
        step();
        check("t1_valid_e3", 32'(rsp_valid), 32'd1);
        check("t1_rsp", 32'({rsp_carry, rsp_err, rsp_tag, rsp_data}), 32'({1'b1, 1'b0, 4'd3, 16'h012C}));
        wait_rsp(1);
        step();
        check("t1_idle_busy", 32'(busy), 32'd0);
        // burst, consumer always ready
        rsp_log.delete();
        stalls = 0;
        send(8'd5, 8'd7, 4'd1, 4'd0);
        send(8'd15, 8'd17, 4'd2, 4'd1);
        send(8'd255, 8'd255, 4'd2, 4'd2);
        send(8'd100, 8'd7, 4'd3, 4'd3);
        check("t2_no_stall", 32'(stalls), 32'd0);
        wait_rsp(4);
        check_rsp("t2_r0", 0, 1'b0, 4'd0, 16'hFFFE);
        check_rsp("t2_r1", 1, 1'b0, 4'd1, 16'h00FF);
        check_rsp("t2_r2", 2, 1'b0, 4'd2, 16'hFE01);
        check_rsp("t2_r3", 3, 1'b0, 4'd3, 16'h000E);
        // backpressure fills the FIFO, then push waits on the freed slot
        rsp_log.delete();
        stalls = 0;
        rsp_ready = 1'b0;
        send(8'd1, 8'd2, 4'd0, 4'd4);
        send(8'd10, 8'd3, 4'd1, 4'd5);
        send(8'd16, 8'd16, 4'd2, 4'd6);
        send(8'd200, 8'd10, 4'd3, 4'd7);
        send(8'd255, 8'd1, 4'd0, 4'd8);
        check("t4_fill_no_stall", 32'(stalls), 32'd0);
        check("t4_full_ready", 32'(req_ready), 32'd0);
        snap = {rsp_valid, rsp_err, rsp_carry, rsp_tag, rsp_data};
        check("t4_first_rsp", 32'(snap), 32'({1'b1, 1'b0, 1'b0, 4'd4, 16'h0003}));
        for (int i = 0; i < 10; i++) begin
            step();
            check("t4_hold", 32'({rsp_valid, rsp_err, rsp_carry, rsp_tag, rsp_data}), 32'({1'b1, 1'b0, 1'b0, 4'd4, 16'h0003}));
        end
        check("t4_no_rsp_stalled", 32'(rsp_log.size()), 32'd0);
        rsp_ready = 1'b1;
        send(8'd16, 8'd3, 4'd2, 4'd9);
        check("t6_push_waited", 32'(stalls != 0), 32'd1);
        wait_rsp(6);
        step(20);
        check("t6_total", 32'(rsp_log.size()), 32'd6);
        check_rsp("t6_r0", 0, 1'b0, 4'd4, 16'h0003);
        check_rsp("t6_r1", 1, 1'b0, 4'd5, 16'h0007);
        check_rsp("t6_r2", 2, 1'b0, 4'd6, 16'h0100);
        check_rsp("t6_r3", 3, 1'b0, 4'd7, 16'h0014);
        check_rsp("t6_r4", 4, 1'b0, 4'd8, 16'h0100);
        check_rsp("t6_r5", 5, 1'b0, 4'd9, 16'h0030);
        // screening
        rsp_log.delete();
        send(8'd10, 8'd0, 4'd3, 4'd5);
        step();
        check("t3_div0_valid", 32'(rsp_valid), 32'd1);
        check("t3_div0_rsp", 32'({rsp_carry, rsp_err, rsp_tag, rsp_data}), 32'({1'b0, 1'b1, 4'd5, 16'h0000}));
        check("t3_alu_kept", 32'({alu_a, alu_sel}), 32'({8'd16, 4'd2}));
        wait_rsp(1);
        send(8'd1, 8'd2, 4'd9, 4'd6);
        wait_rsp(2);
        check_rsp("t3_badop", 1, 1'b1, 4'd6, 16'h0000);
        check("t3_alu_kept2", 32'({alu_a, alu_sel}), 32'({8'd16, 4'd2}));
        // reset while an operation waits and two are queued
        rsp_log.delete();
        send(8'd3, 8'd4, 4'd0, 4'd1);
        send(8'd5, 8'd6, 4'd0, 4'd2);
        send(8'd7, 8'd8, 4'd0, 4'd3);
        check("t5_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_req_ready", 32'(req_ready), 32'd1);
        check("t5_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        step(10);
        check("t5_discarded", 32'(rsp_log.size()), 32'd0);
        send(8'd1, 8'd1, 4'd0, 4'd7);
        wait_rsp(1);
        check_rsp("t5_after", 0, 1'b0, 4'd7, 16'h0002);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
